// File: rtl/tt_harness_pkg.sv
// tt_harness_pkg: shared widths, parameter defaults and run-mode encoding for the stepper harness
package tt_harness_pkg;
    localparam int IO_W_DEF = 8;
    localparam int STAGE_W_DEF = 4;
    localparam int STEP_W_DEF = 8;
    localparam int HALF_LOG2_DEF = 22;
    localparam int RESET_CYCLES_DEF = 21;
    localparam int NUM_STAGES_DEF = 10;
    localparam int CAP_STAGE_DEF = 6;
    localparam logic RUN_STEP = 1'b0;
    localparam logic RUN_FREE = 1'b1;
endpackage

// File: rtl/tt_stepper_if.sv
// tt_stepper_if: control inputs, DUT-facing signals and status outputs of the stepper harness
interface tt_stepper_if import tt_harness_pkg::*; #(
    parameter int IO_W = IO_W_DEF,
    parameter int STAGE_W = STAGE_W_DEF,
    parameter int STEP_W = STEP_W_DEF
);
    logic run_mode, step_req, restart, tt_clk, tt_rst_n, tt_rst, in_reset;
    logic [IO_W-1:0] tt_out, cap;
    logic [STAGE_W-1:0] stage;
    logic [STEP_W-1:0] step_count;
    modport master(
        output run_mode, step_req, restart, tt_out,
        input tt_clk, tt_rst_n, tt_rst, in_reset, cap, stage, step_count
    );
    modport slave(
        input run_mode, step_req, restart, tt_out,
        output tt_clk, tt_rst_n, tt_rst, in_reset, cap, stage, step_count
    );
endinterface

// File: rtl/tt_clk_gen.sv
// tt_clk_gen: prescaled DUT clock with run/single-step gating and a one-deep step request
module tt_clk_gen import tt_harness_pkg::*; #(
    parameter int HALF_LOG2 = HALF_LOG2_DEF
) (
    input  logic clk12MHz,
    input  logic reset_n,
    input  logic run_mode,
    input  logic step_req,
    input  logic restart,
    input  logic in_reset,
    output logic tt_clk,
    output logic rise_tick,
    output logic fall_tick
);
    logic [HALF_LOG2-1:0] pre;
    logic pending, tick, en;
    always_comb begin
        tick = &pre;
        en = in_reset || run_mode == RUN_FREE || tt_clk || pending;
        rise_tick = tick && en && !tt_clk;
        fall_tick = tick && en && tt_clk;
    end
    always_ff @(posedge clk12MHz or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
            tt_clk <= 1'b0;
            pending <= 1'b0;
        end else begin
            pre <= pre + 1'b1;
            if (tick && en) tt_clk <= !tt_clk;
            if (restart || rise_tick) pending <= 1'b0;
            else if (step_req && run_mode == RUN_STEP && !tt_clk) pending <= 1'b1;
        end
    end
endmodule

// File: rtl/tt_stepper.sv
// tt_stepper: TinyTapeout harness sequencing DUT clock, reset, stage tracking and output capture
module tt_stepper import tt_harness_pkg::*; #(
    parameter int IO_W = IO_W_DEF,
    parameter int HALF_LOG2 = HALF_LOG2_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int CAP_STAGE = CAP_STAGE_DEF,
    parameter int STAGE_W = STAGE_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input logic clk12MHz,
    input logic reset_n,
    tt_stepper_if.slave bus
);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] CAP = STAGE_W'(CAP_STAGE);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RESET_CYCLES);
    logic tt_clk, rise_tick, fall_tick, tt_rst_n, in_reset;
    logic [RC_W-1:0] rc;
    logic [STAGE_W-1:0] stage;
    logic [IO_W-1:0] cap;
    logic [STEP_W-1:0] step_count;
    tt_clk_gen #(.HALF_LOG2(HALF_LOG2)) u_clk_gen (
        .clk12MHz(clk12MHz),
        .reset_n(reset_n),
        .run_mode(bus.run_mode),
        .step_req(bus.step_req),
        .restart(bus.restart),
        .in_reset(in_reset),
        .tt_clk(tt_clk),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );
    always_ff @(posedge clk12MHz or negedge reset_n) begin
        if (!reset_n) begin
            tt_rst_n <= 1'b0;
            in_reset <= 1'b1;
            rc <= '0;
            stage <= LAST;
            cap <= '0;
            step_count <= '0;
        end else begin
            if (rise_tick) begin
                stage <= !tt_rst_n ? LAST : stage == LAST ? '0 : stage + 1'b1;
                if (in_reset && rc != RC_MAX) rc <= rc + 1'b1;
            end
            if (fall_tick) cap <= !tt_rst_n ? '0 : stage == CAP ? bus.tt_out : cap;
            if (bus.restart) begin
                tt_rst_n <= 1'b0;
                in_reset <= 1'b1;
                rc <= '0;
                step_count <= '0;
            end else begin
                if (rise_tick && tt_rst_n) step_count <= step_count + 1'b1;
                if (fall_tick && in_reset && rc == RC_MAX) begin
                    tt_rst_n <= 1'b1;
                    in_reset <= 1'b0;
                end
            end
        end
    end
    assign bus.tt_clk = tt_clk;
    assign bus.tt_rst_n = tt_rst_n;
    assign bus.tt_rst = ~tt_rst_n;
    assign bus.in_reset = in_reset;
    assign bus.stage = stage;
    assign bus.cap = cap;
    assign bus.step_count = step_count;
endmodule

// File: tb/tb_tt_stepper.sv
// tb_tt_stepper: scoreboard bench checking tt_clk rises, reset sequencing, capture and stepping
module tb_tt_stepper;
    typedef struct packed {
        logic [3:0] stage;
        logic [7:0] steps;
        logic       rst_n;
    } exp_t;

    logic clk = 1'b0;
    logic clk_on = 1'b1;
    logic reset_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];
    exp_t got;
    logic mon_prev = 1'b0;

    tt_stepper_if #(.IO_W(8), .STAGE_W(4), .STEP_W(8)) bus();

    tt_stepper #(
        .IO_W(8), .HALF_LOG2(2), .RESET_CYCLES(3), .NUM_STAGES(10),
        .CAP_STAGE(6), .STAGE_W(4), .STEP_W(8)
    ) dut (
        .clk12MHz(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    assign bus.tt_out = 8'hA0 + 8'(bus.stage);

    always begin
        #5;
        if (clk_on) clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.tt_clk && !mon_prev) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rise_unexpected stage=%0d step_count=%0d rst_n=%b", bus.stage, bus.step_count, bus.tt_rst_n);
            end else begin
                got = exp_q.pop_front();
                if (bus.stage !== got.stage || bus.step_count !== got.steps || bus.tt_rst_n !== got.rst_n) begin
                    miscompares++;
                    $display("FAIL rise_sb got stage=%0d steps=%0d rst_n=%b want stage=%0d steps=%0d rst_n=%b",
                             bus.stage, bus.step_count, bus.tt_rst_n, got.stage, got.steps, got.rst_n);
                end
            end
        end
        mon_prev = bus.tt_clk;
    end

    function automatic exp_t mk(input logic [3:0] s, input logic [7:0] n, input logic r);
        exp_t e;
        e.stage = s;
        e.steps = n;
        e.rst_n = r;
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            vectors++;
            if (bus.tt_clk !== 1'b0 || bus.tt_rst_n !== 1'b0 || bus.tt_rst !== 1'b1 || bus.in_reset !== 1'b1 ||
                bus.stage !== 4'd9 || bus.cap !== 8'h00 || bus.step_count !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_state pass=%0d got clk=%b rst_n=%b rst=%b in_reset=%b stage=%0d cap=%h steps=%0d want 0 0 1 1 9 00 0",
                         pass, bus.tt_clk, bus.tt_rst_n, bus.tt_rst, bus.in_reset, bus.stage, bus.cap, bus.step_count);
            end
            repeat (3) step();
        end
    endtask

    task automatic test_release();
        int cyc, rises, first, second, bad_stage;
        logic prev_clk, prev_rst_n;
        bit rel_seen, rel_ok;
        cyc = 0; rises = 0; first = 0; second = 0; bad_stage = 0;
        prev_clk = 1'b0; prev_rst_n = 1'b0; rel_seen = 0; rel_ok = 0;
        bus.run_mode = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(4'd9, 8'd0, 1'b0));
        exp_q.push_back(mk(4'd0, 8'd1, 1'b1));
        reset_n = 1'b1;
        while (exp_q.size() != 0 && cyc < 200) begin
            step();
            cyc++;
            if (bus.tt_clk && !prev_clk) begin
                rises++;
                if (rises == 1) first = cyc;
                if (rises == 2) second = cyc;
            end
            if (bus.in_reset && bus.stage !== 4'd9) bad_stage++;
            if (bus.tt_rst_n && !prev_rst_n) begin
                rel_seen = 1;
                rel_ok = prev_clk && !bus.tt_clk && rises == 3 && !bus.in_reset && !bus.tt_rst;
            end
            prev_clk = bus.tt_clk;
            prev_rst_n = bus.tt_rst_n;
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL release_drain got %0d pending rises want 0", exp_q.size()); end
        vectors++;
        if (second - first != 8) begin miscompares++; $display("FAIL tt_clk_period got %0d want 8", second - first); end
        vectors++;
        if (!(rel_seen && rel_ok)) begin miscompares++; $display("FAIL release_edge got seen=%0d aligned=%0d want 1 1", rel_seen, rel_ok); end
        vectors++;
        if (bad_stage != 0) begin miscompares++; $display("FAIL reset_stage got %0d bad cycles want 0", bad_stage); end
    endtask

    task automatic test_free_run();
        int cyc;
        logic prev_clk;
        logic [7:0] exp_cap;
        cyc = 0; prev_clk = bus.tt_clk; exp_cap = 8'h00;
        for (int k = 2; k <= 20; k++) exp_q.push_back(mk(4'((k - 1) % 10), 8'(k), 1'b1));
        while (exp_q.size() != 0 && cyc < 400) begin
            step();
            cyc++;
            if (prev_clk && !bus.tt_clk && bus.stage == 4'd6) exp_cap = 8'hA6;
            vectors++;
            if (bus.cap !== exp_cap) begin
                miscompares++;
                $display("FAIL cap_track cyc=%0d got %h want %h", cyc, bus.cap, exp_cap);
            end
            prev_clk = bus.tt_clk;
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL free_run_drain got %0d want 0", exp_q.size()); end
        vectors++;
        if (bus.step_count !== 8'd20 || bus.stage !== 4'd9 || bus.cap !== 8'hA6) begin
            miscompares++;
            $display("FAIL free_run_end got steps=%0d stage=%0d cap=%h want 20 9 a6", bus.step_count, bus.stage, bus.cap);
        end
    endtask

    task automatic test_single_step();
        int high, lat;
        high = bus.tt_clk ? 1 : 0;
        bus.run_mode = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.tt_clk) high++;
        end
        vectors++;
        if (high != 4 || bus.tt_clk !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_high got high=%0d clk=%b want 4 0", high, bus.tt_clk);
        end
        exp_q.push_back(mk(4'd0, 8'd21, 1'b1));
        high = 0; lat = 0;
        bus.step_req = 1'b1;
        step();
        bus.step_req = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            bus.step_req = 1'b0;
            if (bus.tt_clk) begin
                if (lat == 0) begin
                    lat = i;
                    bus.step_req = 1'b1;
                end
                high++;
            end
        end
        bus.step_req = 1'b0;
        vectors++;
        if (lat < 1 || lat > 4) begin miscompares++; $display("FAIL step_latency got %0d want 1..4", lat); end
        vectors++;
        if (high != 4) begin miscompares++; $display("FAIL step_high got %0d want 4", high); end
        vectors++;
        if (exp_q.size() != 0 || bus.step_count !== 8'd21 || bus.stage !== 4'd0) begin
            miscompares++;
            $display("FAIL step_result got left=%0d steps=%0d stage=%0d want 0 21 0", exp_q.size(), bus.step_count, bus.stage);
        end
    endtask

    task automatic test_restart();
        int cyc, falls, high;
        logic prev_clk;
        cyc = 0; falls = 0; high = 0; prev_clk = bus.tt_clk;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        vectors++;
        if (bus.tt_rst_n !== 1'b0 || bus.in_reset !== 1'b1 || bus.step_count !== 8'd0 || bus.tt_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_next got rst_n=%b in_reset=%b steps=%0d want 0 1 0", bus.tt_rst_n, bus.in_reset, bus.step_count);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(4'd9, 8'd0, 1'b0));
        while ((exp_q.size() != 0 || !bus.tt_rst_n) && cyc < 200) begin
            step();
            cyc++;
            if (prev_clk && !bus.tt_clk) begin
                falls++;
                if (falls == 1) begin
                    vectors++;
                    if (bus.cap !== 8'h00) begin miscompares++; $display("FAIL restart_cap got %h want 00", bus.cap); end
                end
            end
            prev_clk = bus.tt_clk;
        end
        vectors++;
        if (exp_q.size() != 0 || bus.in_reset !== 1'b0 || bus.stage !== 4'd9) begin
            miscompares++;
            $display("FAIL restart_release got left=%0d in_reset=%b stage=%0d want 0 0 9", exp_q.size(), bus.in_reset, bus.stage);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.tt_clk) high++;
        end
        vectors++;
        if (high != 0) begin miscompares++; $display("FAIL restart_pause got %0d high cycles want 0", high); end
    endtask

    task automatic test_async_reset();
        int cyc;
        cyc = 0;
        bus.run_mode = 1'b1;
        for (int k = 1; k <= 8; k++) exp_q.push_back(mk(4'(k - 1), 8'(k), 1'b1));
        while (exp_q.size() != 0 && cyc < 200) begin
            step();
            cyc++;
        end
        vectors++;
        if (exp_q.size() != 0 || bus.cap !== 8'hA6) begin
            miscompares++;
            $display("FAIL pre_async got left=%0d cap=%h want 0 a6", exp_q.size(), bus.cap);
        end
        step();
        clk_on = 1'b0;
        #30;
        vectors++;
        if (bus.tt_clk !== 1'b1) begin miscompares++; $display("FAIL mid_high got %b want 1", bus.tt_clk); end
        reset_n = 1'b0;
        #2;
        vectors++;
        if (bus.tt_clk !== 1'b0 || bus.tt_rst_n !== 1'b0 || bus.stage !== 4'd9 || bus.cap !== 8'h00 ||
            bus.step_count !== 8'd0 || bus.in_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset got clk=%b rst_n=%b stage=%0d cap=%h steps=%0d in_reset=%b want 0 0 9 00 0 1",
                     bus.tt_clk, bus.tt_rst_n, bus.stage, bus.cap, bus.step_count, bus.in_reset);
        end
        clk_on = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_wrap_priority();
        int cyc, high;
        cyc = 0; high = 0;
        bus.run_mode = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(4'd9, 8'd0, 1'b0));
        for (int k = 1; k <= 256; k++) exp_q.push_back(mk(4'((k - 1) % 10), 8'(k), 1'b1));
        reset_n = 1'b1;
        while (exp_q.size() != 0 && cyc < 2500) begin
            step();
            cyc++;
        end
        vectors++;
        if (exp_q.size() != 0 || bus.step_count !== 8'd0 || bus.stage !== 4'd5) begin
            miscompares++;
            $display("FAIL step_wrap got left=%0d steps=%0d stage=%0d want 0 0 5", exp_q.size(), bus.step_count, bus.stage);
        end
        bus.run_mode = 1'b0;
        cyc = 0;
        while (bus.tt_clk && cyc < 10) begin
            step();
            cyc++;
        end
        step();
        bus.step_req = 1'b1;
        bus.restart = 1'b1;
        step();
        bus.step_req = 1'b0;
        bus.restart = 1'b0;
        vectors++;
        if (bus.tt_rst_n !== 1'b0 || bus.in_reset !== 1'b1 || bus.step_count !== 8'd0) begin
            miscompares++;
            $display("FAIL restart_wins got rst_n=%b in_reset=%b steps=%0d want 0 1 0", bus.tt_rst_n, bus.in_reset, bus.step_count);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(4'd9, 8'd0, 1'b0));
        cyc = 0;
        while ((exp_q.size() != 0 || !bus.tt_rst_n) && cyc < 200) begin
            step();
            cyc++;
        end
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.tt_clk) high++;
        end
        vectors++;
        if (exp_q.size() != 0 || high != 0 || bus.step_count !== 8'd0 || bus.stage !== 4'd9) begin
            miscompares++;
            $display("FAIL no_pending got left=%0d high=%0d steps=%0d stage=%0d want 0 0 0 9",
                     exp_q.size(), high, bus.step_count, bus.stage);
        end
    endtask

    initial begin
        bus.run_mode = 1'b1;
        bus.step_req = 1'b0;
        bus.restart = 1'b0;
        test_reset();
        test_release();
        test_free_run();
        test_single_step();
        test_restart();
        test_async_reset();
        test_wrap_priority();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL final_drain got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tt_stepper.md
Name: tt_stepper

Overview:
Parametrised harness controller that drives a TinyTapeout-style DUT from the 12 MHz board clock. It generates a slow DUT clock, sequences the DUT reset, and tracks the DUT execution stage. It captures a DUT output word at a configured stage and counts executed steps. Over the fixed free-running stepper it adds run/single-step modes, a restart request, and configurable widths and stage counts. Its outputs feed LedScan rows in the board top level.

Parameters:
IO_W, 8, width of DUT output bus and capture register
HALF_LOG2, 22, tt_clk toggles every 2^HALF_LOG2 clk12MHz cycles
RESET_CYCLES, 21, tt_clk rising edges held in DUT reset (min 1)
NUM_STAGES, 10, stage counter modulus
CAP_STAGE, 6, stage value at which tt_out is captured (< NUM_STAGES)
STAGE_W, 4, stage width (2^STAGE_W >= NUM_STAGES)
STEP_W, 8, step counter width

Ports:
clk12MHz  in  1  board clock; only clock in the block
reset_n  in  1  asynchronous active-low reset
run_mode  in  1  1 = free-run, 0 = single-step; sampled only at ticks
step_req  in  1  one-cycle pulse, sync to clk12MHz; requests one tt_clk period
restart  in  1  one-cycle pulse; re-enters DUT reset sequence
tt_out  in  IO_W  DUT outputs
tt_clk  out  1  DUT clock (register output, glitch-free)
tt_rst_n  out  1  DUT reset, active low
tt_rst  out  1  inverse of tt_rst_n
stage  out  STAGE_W  expected DUT stage
cap  out  IO_W  word captured at CAP_STAGE (e.g. PC)
step_count  out  STEP_W  rising edges since reset release, wraps
in_reset  out  1  high while reset sequence active

Behaviour:
- Async reset: prescaler=0, tt_clk=0, tt_rst_n=0, in_reset=1, rst count=0, stage=NUM_STAGES-1, cap=0, step_count=0, no step pending.
- Prescaler: HALF_LOG2-bit counter, free-running. "tick" = cycle in which it wraps all-ones -> 0. All tt_clk changes occur on ticks, registered, visible the cycle after the tick.
- Clock enable at tick: in_reset=1 or run_mode=1 -> toggle. run_mode=0: if tt_clk=1, toggle (the high phase always completes); if tt_clk=0, toggle only if a step is pending, then clear pending.
- step_req: sets pending when run_mode=0, tt_clk=0 and no step is pending; ignored otherwise (no queueing). Latency to tt_clk rise is at most 2^HALF_LOG2 cycles; the high phase lasts exactly 2^HALF_LOG2 cycles.
- Rising tick (tt_clk 0->1): rst count++ (saturating) while in_reset. stage <= NUM_STAGES-1 if tt_rst_n=0; otherwise wraps NUM_STAGES-1 -> 0, else +1. step_count++ (wrapping) only if tt_rst_n=1.
- Falling tick (tt_clk 1->0):
  - cap <= 0 if tt_rst_n=0 (pre-tick value).
  - Otherwise cap <= tt_out if stage==CAP_STAGE, else hold.
  - Then, if in_reset and rst count == RESET_CYCLES: tt_rst_n <= 1, in_reset <= 0. Reset release is therefore always aligned to a falling edge.
- restart pulse: next cycle tt_rst_n=0, in_reset=1, rst count=0, pending cleared. tt_clk state and prescaler are untouched. step_count is cleared on the same cycle.
- restart has priority over step_req in the same cycle. restart during an active reset sequence restarts the count.
- tt_out is used only at falling ticks; no synchroniser (DUT is clocked by tt_clk).
- tt_rst is combinational ~tt_rst_n.

Decomposition:
- Package tt_harness_pkg holds: stage/step width localparams, default HALF_LOG2, RESET_CYCLES, NUM_STAGES and CAP_STAGE constants, and the run-mode encoding.
- One sub-module, tt_clk_gen: contains the prescaler, tick, the tt_clk toggle with run/step gating, and the pending flag. It outputs tt_clk, rise_tick and fall_tick.
- Stage, capture and reset sequencing stay in tt_stepper.

Test Plan:
Bench config for all scenarios: HALF_LOG2=2, RESET_CYCLES=3, NUM_STAGES=10, CAP_STAGE=6. tt_out model = 8'hA0+stage.
1. Release reset_n, run_mode=1 -> tt_clk period 8 cycles; stage=9 throughout reset; tt_rst_n rises at the falling tick after the 3rd rising edge; next rising edge stage=0, step_count=1.
2. Free-run 20 tt_clk periods -> cap=0xA6 after the first falling edge at stage 6; holds 0xA6 otherwise; stage sequence 0..9,0 wraps; step_count=20.
3. run_mode=0 during a high phase -> high phase completes, tt_clk stays 0. step_req -> exactly one 4-cycle high pulse, stage+1, step_count+1. Second step_req during that pulse -> no extra pulse.
4. restart mid-run with run_mode=0 -> tt_rst_n=0 next cycle, step_count=0. Clock free-runs 3 rising edges; cap=0 at the first falling tick; stage=9 until release; then clock pauses again.
5. Assert reset_n low mid-high-phase with clk12MHz stopped -> tt_clk=0, tt_rst_n=0, stage=9, cap=0 immediately.
6. Preload run to step_count=255 -> next rising edge gives 0; step_req and restart in the same cycle -> restart wins, no step pending.
